// File: rtl/timer_pkg.sv
// Shared definitions for the timepulse generator.
//   tp_state_t   : controller states (RUN, JAM, STOPPED, STEP)
//   DEF_*        : default parameter values for timepulse_gen
//   jam_width()  : width of the restart hold counter for a given hold length
package timer_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        JAM     = 2'd1,
        STOPPED = 2'd2,
        STEP    = 2'd3
    } tp_state_t;

    localparam int DEF_N_PH     = 4;
    localparam int DEF_N_TP     = 12;
    localparam int DEF_RT_PH    = 0;
    localparam int DEF_WT_PH    = 1;
    localparam int DEF_CT_PH    = 2;
    localparam int DEF_OVF_TP   = 6;
    localparam int DEF_GOJAM_TP = 2;

    // Bits needed to hold the values 0..n; never narrower than one bit.
    function automatic int jam_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ring_ctr.sv
// One-hot ring counter.
//   clk   : clock
//   srst  : synchronous reset, forces the single hot bit to RST_BIT
//   load  : same effect as srst (used for restart requests)
//   hold  : freezes the ring, overrides adv
//   adv   : rotate the hot bit up by one position, wrapping W-1 -> 0
//   q     : current one-hot value, straight from the register
module ring_ctr #(
    parameter int W       = 4,
    parameter int RST_BIT = 0
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic         hold,
    input  logic         adv,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;
    logic [W-1:0] rst_val;
    logic [W-1:0] rot_val;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bits
            assign rst_val[gi] = (gi == RST_BIT);
            // Bit gi receives the bit just below it; bit 0 receives the top bit.
            assign rot_val[gi] = q_reg[(gi + W - 1) % W];
        end
    endgenerate

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = rst_val;
        end else if (!hold && adv) begin
            q_next = rot_val;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            q_reg <= rst_val;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/timepulse_gen.sv
// Phase / timepulse sequencer with restart (GOJAM), manual stop and
// single-step control, plus overflow/underflow sensing of the write bus.
//   CLOCK, SIM_RST        : clock, synchronous active-high reset
//   GOJ1, STRT1, STRT2    : restart requests (ORed)
//   MSTP, MSTRTP          : manual stop level, single-step pulse
//   WL15, WL16            : write-bus sign bits
//   T, PHS                : one-hot timepulse / phase (registered)
//   RT, WT, CT            : phase strobes
//   EOC                   : end-of-cycle pulse (registered)
//   GOJAM, STOP           : restart in progress / machine frozen
//   OVF, UNF              : overflow / underflow pulses (registered)
module timepulse_gen
    import timer_pkg::*;
#(
    parameter int N_PH     = DEF_N_PH,
    parameter int N_TP     = DEF_N_TP,
    parameter int RT_PH    = DEF_RT_PH,
    parameter int WT_PH    = DEF_WT_PH,
    parameter int CT_PH    = DEF_CT_PH,
    parameter int OVF_TP   = DEF_OVF_TP,
    parameter int GOJAM_TP = DEF_GOJAM_TP
) (
    input  logic            CLOCK,
    input  logic            SIM_RST,
    input  logic            GOJ1,
    input  logic            STRT1,
    input  logic            STRT2,
    input  logic            MSTP,
    input  logic            MSTRTP,
    input  logic            WL15,
    input  logic            WL16,
    output logic [N_TP-1:0] T,
    output logic [N_PH-1:0] PHS,
    output logic            RT,
    output logic            WT,
    output logic            CT,
    output logic            EOC,
    output logic            GOJAM,
    output logic            STOP,
    output logic            OVF,
    output logic            UNF
);

    localparam int             JW       = jam_width(GOJAM_TP);
    localparam logic [JW-1:0]  JAM_LOAD = JW'(GOJAM_TP);

    tp_state_t      state_reg, state_next;
    logic [JW-1:0]  jam_cnt_reg, jam_cnt_next;
    logic           eoc_reg, eoc_next;
    logic           ovf_reg, ovf_next;
    logic           unf_reg, unf_next;

    logic req;
    logic running;
    logic ph_wrap;
    logic active;      // RUN or STEP: the states that do real work
    logic jam_done;
    logic tp_hold;
    logic tp_adv;
    logic ovf_sample;

    assign req      = GOJ1 | STRT1 | STRT2;
    assign running  = (state_reg != STOPPED);
    assign ph_wrap  = PHS[N_PH-1];
    assign active   = (state_reg == RUN) || (state_reg == STEP);
    // Last wrap of the restart hold: the timepulse ring is released on this
    // edge so it rolls from N_TP-1 to 0 exactly as GOJAM drops.
    assign jam_done = (state_reg == JAM) && ph_wrap && (jam_cnt_reg <= JW'(1));
    assign tp_hold  = (state_reg == JAM) && !jam_done;
    assign tp_adv   = running && ph_wrap;

    ring_ctr #(
        .W       (N_PH),
        .RST_BIT (0)
    ) u_ph_ring (
        .clk  (CLOCK),
        .srst (SIM_RST),
        .load (req),
        .hold (1'b0),
        .adv  (running),
        .q    (PHS)
    );

    ring_ctr #(
        .W       (N_TP),
        .RST_BIT (N_TP - 1)
    ) u_tp_ring (
        .clk  (CLOCK),
        .srst (SIM_RST),
        .load (req),
        .hold (tp_hold),
        .adv  (tp_adv),
        .q    (T)
    );

    assign ovf_sample = active && T[OVF_TP] && PHS[CT_PH];

    always_comb begin
        state_next   = state_reg;
        jam_cnt_next = jam_cnt_reg;
        eoc_next     = active && T[N_TP-1] && ph_wrap;
        ovf_next     = ovf_sample && WL16 && !WL15;
        unf_next     = ovf_sample && !WL16 && WL15;

        if (req) begin
            state_next   = JAM;
            jam_cnt_next = JAM_LOAD;
        end else begin
            case (state_reg)
                RUN: begin
                    if (ph_wrap && MSTP) begin
                        state_next = STOPPED;
                    end
                end
                JAM: begin
                    if (jam_done) begin
                        state_next   = RUN;
                        jam_cnt_next = '0;
                    end else if (ph_wrap) begin
                        jam_cnt_next = jam_cnt_reg - JW'(1);
                    end
                end
                STOPPED: begin
                    if (!MSTP) begin
                        state_next = RUN;
                    end else if (MSTRTP) begin
                        state_next = STEP;
                    end
                end
                STEP: begin
                    if (ph_wrap) begin
                        state_next = MSTP ? STOPPED : RUN;
                    end
                end
                default: state_next = JAM;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            state_reg   <= JAM;
            jam_cnt_reg <= JAM_LOAD;
            eoc_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            jam_cnt_reg <= jam_cnt_next;
            eoc_reg     <= eoc_next;
            ovf_reg     <= ovf_next;
            unf_reg     <= unf_next;
        end
    end

    assign RT    = running && PHS[RT_PH];
    assign WT    = running && PHS[WT_PH];
    assign CT    = running && PHS[CT_PH];
    assign EOC   = eoc_reg;
    assign GOJAM = (state_reg == JAM);
    assign STOP  = (state_reg == STOPPED);
    assign OVF   = ovf_reg;
    assign UNF   = unf_reg;

endmodule

// File: doc/timepulse_gen.md
TIMEPULSE_GEN -- requirements
Module: timepulse_gen

Interface
REQ-001 Parameter N_PH, 4: phases per timepulse; legal range 2..8.
REQ-002 Parameter N_TP, 12: timepulses per memory cycle; legal range 2..16.
REQ-003 Parameter RT_PH / WT_PH / CT_PH, 0 / 1 / 2: phase index at which RT, WT and CT strobe; each must be less than N_PH.
REQ-004 Parameter OVF_TP, 6: timepulse index at which WL15/WL16 are sampled for overflow.
REQ-005 Parameter GOJAM_TP, 2: number of full timepulses GOJAM holds after the last restart request.
REQ-006 CLOCK  in  1  the single system clock; all logic acts on its rising edge.
REQ-007 SIM_RST  in  1  reset, synchronous, active-high.
REQ-008 GOJ1, STRT1, STRT2  in  1 each  restart requests; the OR of the three is the request REQ.
REQ-009 MSTP  in  1  manual-stop request, level-sensitive.
REQ-010 MSTRTP  in  1  single-step pulse, one cycle wide, honoured only in STOPPED.
REQ-011 WL15, WL16  in  1 each  write-bus sign bits used for overflow sensing.
REQ-012 T  out  N_TP  one-hot timepulse, registered.
REQ-013 PHS  out  N_PH  one-hot phase, registered.
REQ-014 RT, WT, CT  out  1 each  phase strobes, combinational from the phase register.
REQ-015 EOC  out  1  end of cycle.
REQ-016 GOJAM  out  1  restart in progress.
REQ-017 STOP  out  1  machine frozen.
REQ-018 OVF, UNF  out  1 each  overflow / underflow pulses, registered.

Function
REQ-019 The phase counter ph shall advance by 1 on each CLOCK edge when running and wrap from N_PH-1 to 0.
REQ-020 The timepulse counter tp shall advance only on a phase wrap and wrap from N_TP-1 to 0.
REQ-021 RT, WT and CT shall each be high exactly when running and ph equals RT_PH, WT_PH or CT_PH respectively, and low otherwise.
REQ-022 EOC shall be high for exactly one cycle when tp=N_TP-1 and ph=N_PH-1 in state RUN or STEP.
REQ-023 The state machine shall have four states: RUN, JAM, STOPPED, STEP.
REQ-024 From any state, REQ=1 shall force JAM on the next edge, with tp=N_TP-1, ph=0, GOJAM=1, STOP=0, and the jam counter loaded with GOJAM_TP.
REQ-025 In JAM, tp shall stay at N_TP-1 while ph runs normally.
REQ-026 In JAM, each phase wrap shall decrement the jam counter, and any REQ shall reload it.
REQ-027 When the jam counter reaches 0 on a wrap, the block shall go to RUN with tp=0, ph=0 and GOJAM=0 on the same edge.
REQ-028 In RUN, if MSTP=1 at a timepulse boundary (ph=N_PH-1), the block shall enter STOPPED on that edge.
REQ-029 On entry to STOPPED, tp shall still advance once (the boundary edge completes), so the block freezes at the start of the next timepulse with ph=0 and STOP=1.
REQ-030 In STOPPED, ph and tp shall be frozen, RT/WT/CT/EOC shall be 0, and T and PHS shall hold their values.
REQ-031 STOPPED with MSTP=0 shall go to RUN on the next edge.
REQ-032 STOPPED with MSTRTP=1 and MSTP=1 shall go to STEP on the next edge with STOP=0.
REQ-033 STEP shall run exactly N_PH cycles (one timepulse).
REQ-034 At the boundary ending a STEP, the block shall go to STOPPED if MSTP=1, otherwise to RUN.
REQ-035 When REQ and MSTP are high together, REQ shall win.
REQ-036 MSTRTP outside STOPPED shall be ignored.
REQ-037 On the edge where tp=OVF_TP and ph=CT_PH in RUN or STEP, OVF shall load (WL16 & ~WL15) and UNF shall load (~WL16 & WL15).
REQ-038 On every other edge, OVF and UNF shall load 0, giving one-cycle pulses.
REQ-039 The jam counter width shall be clog2(GOJAM_TP+1).
REQ-040 ph and tp shall be held internally as one-hot vectors so that T and PHS are direct register outputs.

Reset
REQ-041 On a CLOCK edge with SIM_RST=1, the block shall enter JAM with T=one-hot bit N_TP-1, PHS=one-hot bit 0, GOJAM=1, STOP=0, and OVF=UNF=EOC=0.
REQ-042 On that same reset edge, the jam counter shall be loaded with GOJAM_TP.
REQ-043 SIM_RST shall take priority over all other inputs.
REQ-044 SIM_RST asserted mid-STEP or mid-STOPPED shall abort that state immediately.

Structure
REQ-045 A package timer_pkg shall hold the state enum (RUN, JAM, STOPPED, STEP) and the default parameter constants.
REQ-046 A sub-module ring_ctr (parametric one-hot ring with advance and hold inputs, reset to a parametrised bit) shall be instantiated twice, once for phase and once for timepulse.

Verification
REQ-047 Reset then idle, defaults: GOJAM is high for 8 cycles with T[11]=1, then T[0]=1 and PHS[0]=1; EOC first pulses 48 cycles after GOJAM falls.
REQ-048 Steady RUN: every 4-cycle window shows RT at PHS[0], WT at PHS[1], CT at PHS[2], and T advances T[0]..T[11] before wrapping.
REQ-049 MSTP raised during T[4] PHS[1]: the block freezes at T[5] PHS[0] with STOP=1; three MSTRTP pulses each advance exactly one timepulse, ending at T[8] PHS[0].
REQ-050 GOJ1 pulsed while STOPPED: STOP drops next cycle and GOJAM=1 with T[11]; a second GOJ1 one timepulse later extends GOJAM to 3 timepulses total.
REQ-051 At T[6] CT with WL16=1 and WL15=0: OVF=1 for exactly one cycle and UNF=0; with WL16=0 and WL15=1, UNF pulses instead; with equal bits, neither pulses.
REQ-052 Parameters N_PH=2 and N_TP=3: EOC period is 6 cycles, and RT and WT alternate with CT_PH=1.
